// File: rtl/timing_nco.sv
// timing_nco: interpolation-control NCO for a Gardner symbol timing loop.
// A modulo-1 decrementing counter (eta, Q1.16) steps by the control word W once
// per input sample. Each underflow emits a symbol strobe and the fractional
// interval mu (Q0.16) for the interpolator.
//
// Optional feature macro: TIMING_NCO_EXACT_MU_EN
//   defined   : mu = eta_old / W from a 16-iteration serial restoring divider,
//               mu/mu_valid registered 17 cycles after the sample, busy/overrun live.
//   undefined : mu = min(eta_old << 1, 0xFFFF) (W ~= 0.5 approximation),
//               mu/mu_valid coincident with strobe, busy/overrun tied low.
module timing_nco #(
    parameter logic [31:0] W0       = 32'h0000_8000,
    parameter int unsigned FE_SHIFT = 4,
    parameter logic [31:0] W_MIN    = 32'h0000_4000,
    parameter logic [31:0] W_MAX    = 32'h0000_C000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_en,
    input  logic [31:0] fe,
    input  logic        loop_out_en,
    output logic        strobe,
    output logic [15:0] mu,
    output logic        mu_valid,
    output logic        busy,
    output logic        overrun
);

    // ------------------------------------------------------------------
    // Loop filter capture and control word
    // ------------------------------------------------------------------
    logic        [31:0] fe_r;
    logic signed [32:0] fe_ext_s;
    logic signed [32:0] fe_shift_s;
    logic signed [32:0] w_sum_s;
    logic        [16:0] w_s;

    // Latch the loop filter output; a sample on the same edge still sees the old value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fe_r <= 32'h0000_0000;
        end else if (loop_out_en) begin
            fe_r <= fe;
        end else begin
            fe_r <= fe_r;
        end
    end

    // Control word: nominal plus scaled error, clamped at 33-bit signed width.
    always_comb begin
        fe_ext_s   = $signed({fe_r[31], fe_r});
        fe_shift_s = fe_ext_s >>> FE_SHIFT;
        w_sum_s    = $signed({1'b0, W0}) + fe_shift_s;
        if (w_sum_s < $signed({1'b0, W_MIN})) begin
            w_s = W_MIN[16:0];
        end else if (w_sum_s > $signed({1'b0, W_MAX})) begin
            w_s = W_MAX[16:0];
        end else begin
            w_s = w_sum_s[16:0];
        end
    end

    // ------------------------------------------------------------------
    // Modulo-1 counter
    // ------------------------------------------------------------------
    logic [16:0] eta_r;
    logic [16:0] eta_nx_s;
    logic        underflow_s;
    logic        strobe_r;

    // Next counter value; an underflow wraps by adding one (0x1_0000).
    always_comb begin
        underflow_s = 1'b0;
        eta_nx_s    = eta_r;
        if (sample_en) begin
            if (eta_r < w_s) begin
                underflow_s = 1'b1;
                eta_nx_s    = eta_r + 17'h1_0000 - w_s;
            end else begin
                underflow_s = 1'b0;
                eta_nx_s    = eta_r - w_s;
            end
        end else begin
            underflow_s = 1'b0;
            eta_nx_s    = eta_r;
        end
    end

    // Counter register and symbol strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            eta_r    <= 17'h0_FFFF;
            strobe_r <= 1'b0;
        end else begin
            eta_r    <= eta_nx_s;
            strobe_r <= underflow_s;
        end
    end

    assign strobe = strobe_r;

`ifdef TIMING_NCO_EXACT_MU_EN
    // ------------------------------------------------------------------
    // Exact mu: serial restoring divider, one quotient bit per cycle
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [16:0] rem_r;
    logic [16:0] rem_nx_s;
    logic [15:0] quo_r;
    logic [15:0] quo_nx_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nx_s;
    logic [16:0] wdiv_r;
    logic [16:0] wdiv_nx_s;
    logic [15:0] mu_r;
    logic [15:0] mu_nx_s;
    logic        mu_valid_r;
    logic        mu_valid_nx_s;
    logic        busy_r;
    logic        busy_nx_s;
    logic        overrun_r;
    logic        overrun_nx_s;
    logic [17:0] rem_dbl_s;
    logic [17:0] rem_sub_s;
    logic        q_bit_s;

    // Divider state register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            rem_r      <= 17'h0_0000;
            quo_r      <= 16'h0000;
            cnt_r      <= 4'd0;
            wdiv_r     <= 17'h0_0000;
            mu_r       <= 16'h0000;
            mu_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            rem_r      <= rem_nx_s;
            quo_r      <= quo_nx_s;
            cnt_r      <= cnt_nx_s;
            wdiv_r     <= wdiv_nx_s;
            mu_r       <= mu_nx_s;
            mu_valid_r <= mu_valid_nx_s;
            busy_r     <= busy_nx_s;
            overrun_r  <= overrun_nx_s;
        end
    end

    // Divider next state: load on underflow, iterate 16 times, flag overlapping underflows.
    always_comb begin
        state_nx_s    = state_r;
        rem_nx_s      = rem_r;
        quo_nx_s      = quo_r;
        cnt_nx_s      = cnt_r;
        wdiv_nx_s     = wdiv_r;
        mu_nx_s       = mu_r;
        mu_valid_nx_s = 1'b0;
        busy_nx_s     = busy_r;
        overrun_nx_s  = overrun_r;
        rem_dbl_s     = {rem_r, 1'b0};
        rem_sub_s     = rem_dbl_s - {1'b0, wdiv_r};
        q_bit_s       = (rem_dbl_s >= {1'b0, wdiv_r});
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (underflow_s) begin
                    // W is frozen for the whole division so a mid-division fe update cannot skew mu.
                    state_nx_s = ST_DIV;
                    rem_nx_s   = eta_r;
                    quo_nx_s   = 16'h0000;
                    cnt_nx_s   = 4'd15;
                    wdiv_nx_s  = w_s;
                    busy_nx_s  = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                    busy_nx_s  = 1'b0;
                end
            end
            ST_DIV: begin
                if (underflow_s) begin
                    overrun_nx_s = 1'b1;
                end else begin
                    overrun_nx_s = overrun_r;
                end
                if (q_bit_s) begin
                    rem_nx_s = rem_sub_s[16:0];
                end else begin
                    rem_nx_s = rem_dbl_s[16:0];
                end
                quo_nx_s = {quo_r[14:0], q_bit_s};
                if (cnt_r == 4'd0) begin
                    state_nx_s    = ST_DONE;
                    mu_nx_s       = {quo_r[14:0], q_bit_s};
                    mu_valid_nx_s = 1'b1;
                    busy_nx_s     = 1'b0;
                end else begin
                    state_nx_s = ST_DIV;
                    cnt_nx_s   = cnt_r - 4'd1;
                    busy_nx_s  = 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    assign mu       = mu_r;
    assign mu_valid = mu_valid_r;
    assign busy     = busy_r;
    assign overrun  = overrun_r;

`else
    // ------------------------------------------------------------------
    // Approximate mu: eta_old / 0.5, saturated to Q0.16
    // ------------------------------------------------------------------
    logic [17:0] eta_dbl_s;
    logic [15:0] mu_apx_s;
    logic [15:0] mu_r;
    logic        mu_valid_r;

    // Double the captured counter value and saturate below one.
    always_comb begin
        eta_dbl_s = {eta_r, 1'b0};
        if (eta_dbl_s > 18'h0_FFFF) begin
            mu_apx_s = 16'hFFFF;
        end else begin
            mu_apx_s = eta_dbl_s[15:0];
        end
    end

    // mu register, updated alongside the strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mu_r       <= 16'h0000;
            mu_valid_r <= 1'b0;
        end else if (underflow_s) begin
            mu_r       <= mu_apx_s;
            mu_valid_r <= 1'b1;
        end else begin
            mu_r       <= mu_r;
            mu_valid_r <= 1'b0;
        end
    end

    assign mu       = mu_r;
    assign mu_valid = mu_valid_r;
    assign busy     = 1'b0;
    assign overrun  = 1'b0;
`endif

endmodule
